// File: rtl/rr_select_arb8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_select_arb8_pkg
// Description : Shared widths and state encodings for the 8-way round-robin
//               select arbiter and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_select_arb8_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;
  localparam int ARB_CNT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_select_arb8_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_select_arb8_if
// Description : Request/grant bundle between requesters (master) and the
//               round-robin arbiter (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_select_arb8_if;

  logic [rr_select_arb8_pkg::ARB_N-1:0]     req;
  logic                                     done;
  logic [rr_select_arb8_pkg::ARB_IDX_W-1:0] grant_idx;
  logic                                     grant_en;
  logic                                     timeout;

  modport master (
    output req,
    output done,
    input  grant_idx,
    input  grant_en,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant_idx,
    output grant_en,
    output timeout
  );

endinterface
`default_nettype wire

// File: rtl/rr_select_arb8_pick8.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick8
// Description : Combinational rotating-priority pick over 8 requests. The
//               index ptr has highest priority, then ptr+1, ... mod 8.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick8 (
  input  wire logic [7:0] req,
  input  wire logic [2:0] ptr,
  output logic            any,
  output logic [2:0]      idx
);

  // Scan from the lowest priority upward so the highest-priority hit is the
  // last one assigned.
  always_comb begin
    logic [2:0] w_cand;
    any    = 1'b0;
    idx    = ptr;
    w_cand = ptr;
    for (int i = 7; i >= 0; i--) begin
      w_cand = ptr + 3'(i);
      if (req[w_cand]) begin
        any = 1'b1;
        idx = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_select_arb8.sv
`default_nettype none
// ============================================================================
// Module      : rr_select_arb8
// Description : Round-robin arbiter over eight requesters with registered
//               3-bit select index, enable and hold-limit timeout pulse.
//               Grants are held until done, request withdrawal or HOLD_MAX.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_select_arb8
  import rr_select_arb8_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  rr_select_arb8_if.slave   bus
);

  // Counter value at which the grant has been held for HOLD_MAX cycles.
  localparam logic [ARB_CNT_W-1:0] C_CNT_LIM = ARB_CNT_W'(HOLD_MAX - 1);
  localparam logic                 C_LIM_ON  = (HOLD_MAX != 0);

  arb_state_t             r_state, w_state_nxt;
  logic [ARB_IDX_W-1:0]   r_ptr,   w_ptr_nxt;
  logic [ARB_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
  logic [ARB_IDX_W-1:0]   r_idx,   w_idx_nxt;
  logic                   r_en,    w_en_nxt;
  logic                   r_to,    w_to_nxt;

  logic                   w_any;
  logic [ARB_IDX_W-1:0]   w_win;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_win)
  );

  // State and output registers; reset also clears the rotation pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_en    <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_en    <= w_en_nxt;
      r_to    <= w_to_nxt;
    end
  end

  // Next-state logic: grant on any request, release on done, withdrawal or
  // hold limit (timeout only when the limit is the sole cause).
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_en_nxt    = r_en;
    w_to_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt = ST_GRANT;
          w_idx_nxt   = w_win;
          w_en_nxt    = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + ARB_CNT_W'(1);
        if (bus.done || !bus.req[r_idx]) begin
          w_state_nxt = ST_IDLE;
          w_en_nxt    = 1'b0;
          w_ptr_nxt   = r_idx + ARB_IDX_W'(1);
        end else if (C_LIM_ON && (r_cnt == C_CNT_LIM)) begin
          w_state_nxt = ST_IDLE;
          w_en_nxt    = 1'b0;
          w_ptr_nxt   = r_idx + ARB_IDX_W'(1);
          w_to_nxt    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_en_nxt    = 1'b0;
      end
    endcase
  end

  assign bus.grant_idx = r_idx;
  assign bus.grant_en  = r_en;
  assign bus.timeout   = r_to;

endmodule
`default_nettype wire

// File: doc/rr_select_arb8.md
# rr_select_arb8

Round-robin arbiter over eight requesters producing a registered 3-bit select index and enable. It sits directly upstream of the team's 3-to-8 enable decoder: `grant_idx` drives the decoder select and `grant_en` drives its enable, so exactly one one-hot line is active per grant. Grants are held until released by the owner, by request withdrawal, or by a hold-time limit.

## Interface
- `HOLD_MAX`, default 15: maximum grant length in cycles, legal range 0..255. 0 disables the limit.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req` in 8: request vector, bit i for requester i. Level-sensitive.
- `done` in 1: single-cycle release from the current owner. Ignored when no grant is active.
- `grant_idx` out 3: index of the granted requester, registered. Reset 3'd0. Holds its last value while `grant_en`=0.
- `grant_en` out 1: grant valid, registered. Reset 0.
- `timeout` out 1: one-cycle pulse when a grant is forcibly released by `HOLD_MAX`, registered. Reset 0.

## Operation
- States are IDLE and GRANT. Reset enters IDLE with `ptr`=0 and hold counter `cnt`=0.
- `ptr` (3 bits) is the highest-priority index.
- Arbitration is combinational. It scans `ptr`, `ptr+1`, … mod 8 and picks the first set `req` bit.
- IDLE: if `req` != 0, then go to GRANT, set `grant_idx`=winner, `grant_en`=1, `cnt`=0. Otherwise stay in IDLE.
- GRANT: `cnt` increments each cycle, saturating at 8 bits. Release conditions, in priority order:
  - `done`=1.
  - `req[grant_idx]`=0.
  - `HOLD_MAX`≠0 and `cnt`==`HOLD_MAX`-1. This release also pulses `timeout`=1 for one cycle.
- On release: `grant_en`=0, `ptr`=`grant_idx`+1 (7 wraps to 0), go to IDLE.
- `timeout` is suppressed when `done` or request withdrawal coincides with the limit cycle. That counts as a normal release.
- Changes to `req` bits other than the owner's do not affect an active grant.
- Assertion of `rst_n`=0 mid-grant takes effect at the next edge and forces reset values, including `ptr`=0.

## Timing
- Grant latency: `req` set before edge N with IDLE → `grant_en`=1 and valid `grant_idx` after edge N.
- Release latency: a release condition sampled at edge M → `grant_en`=0 after edge M.
- Back-to-back grants: `grant_en` is low for exactly 1 cycle between consecutive grants.
- Peak throughput is one grant per 2 cycles.
- `grant_idx` and `grant_en` change only on clock edges and are glitch-free for direct connection to the decoder.
- A grant lasts at least 1 cycle. With `HOLD_MAX`=H (H>0), it lasts at most H cycles.
- `HOLD_MAX`=1 gives exactly 1-cycle grants. `timeout` pulses on each unless a normal release coincides.

## Structure
- Shared package holds:
  - `ARB_N`=8 and `ARB_IDX_W`=3.
  - State encodings `ST_IDLE`=1'b0 and `ST_GRANT`=1'b1.
  - Counter width `ARB_CNT_W`=8.
- One sub-module, `rr_pick8`: combinational rotating priority pick.
  - Inputs: `req[7:0]`, `ptr[2:0]`.
  - Outputs: `any`, `idx[2:0]`.
  - Reusable by other arbiters.
- Top level holds the FSM, `ptr`, `cnt`, and output registers.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with `req`=8'hFF → `grant_en`=0, `grant_idx`=0, `timeout`=0. First grant after release of reset is index 0.
- Rotation: `req`=8'hFF held, `done` pulsed 1 cycle after each grant → grant order 0,1,2,…,7,0, with `grant_en` low 1 cycle between grants.
- Wrap and skip: `ptr`=6 (after granting 5), `req`=8'b0000_0101 → grant 0, then grant 2.
- Withdrawal: grant 3 active, drop `req[3]` → `grant_en`=0 next cycle, `timeout`=0, next search starts at 4.
- Timeout: `HOLD_MAX`=4, `req`=8'h01, no `done` → `grant_en` high exactly 4 cycles, `timeout`=1 on the cycle `grant_en` falls, then regrant 0. Repeat with `done` on the 4th cycle → `timeout` stays 0.
- Mid-grant reset: grant 5 active, `rst_n`=0 for 1 cycle → outputs return to reset values. With `req`=8'hFF, the next grant is 0.
